hazard_ctrl: RTL and testbench

- Hazard and stall controller for the 5-stage pipelined ARM datapath.
- Generates the forwarding selects for the three execute-stage operand bypass muxes (A, B, C), plus load-use stalls, PC-write flushes and early-branch flushes.
- Sequences multi-cycle execute operations (long multiply / multiply-accumulate) by freezing F/D/E and bubbling M for a fixed number of cycles.
- Sits beside the datapath and consumes its Match_* comparator outputs.

---
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and stall controller for the 5-stage pipelined ARM
// datapath.
//
// It produces:
//   - the execute-stage bypass selects for operands A, B and C;
//   - load-use stalls;
//   - flushes for R15 writes and for early (decode-stage) branches;
//   - the freeze/bubble sequence for multi-cycle execute operations.
//
// A multi-cycle operation (long multiply, multiply-accumulate) stays in E for
// MC_CYCLES cycles. While it is there, F/D/E are frozen and M receives bubbles.
//
// Parameters:
//   MC_CYCLES  cycles a multi-cycle op occupies E (1..16)
//   CW         width of the sequencer counter (2^CW >= MC_CYCLES)
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   Match_{1,2,3}E_{M,W}             E-stage source matches an M/W destination
//   Match_12D_E                      a D-stage source matches the E destination
//   RegWriteE/M/W                    per-stage destination write enables
//   MemtoRegE                        the instruction in E is a load
//   PCSrcD/E/M/W                     the instruction in that stage writes R15
//   BranchTakenD                     early branch resolved taken in decode
//   MultiCycleE                      the instruction in E is a multi-cycle op
//   ForwardAE/BE/CE                  00 reg file, 01 ResultW, 10 ALUOutM
//   StallF/D/E                       hold PC, D register, E register
//   FlushD/E/M                       bubble the D/E/M pipeline registers
//   TakeBranchD                      qualified branch select for the PC mux
//   BusyE                            multi-cycle sequencer active
module hazard_ctrl #(
  parameter int MC_CYCLES = 3,
  parameter int CW        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Match_1E_M,
  input  logic       Match_1E_W,
  input  logic       Match_2E_M,
  input  logic       Match_2E_W,
  input  logic       Match_3E_M,
  input  logic       Match_3E_W,
  input  logic       Match_12D_E,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenD,
  input  logic       MultiCycleE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic [1:0] ForwardCE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       TakeBranchD,
  output logic       BusyE
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mc_state_t;

  // The first cycle of an op is spent in IDLE. The counter therefore covers
  // only the remaining MC_CYCLES-1 cycles, and the last of those is the
  // non-stalled cycle on which the op leaves E.
  localparam logic [CW-1:0] CNT_LOAD = (MC_CYCLES > 1) ? CW'(MC_CYCLES - 2) : '0;

  mc_state_t     state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          mc_stall;
  logic          ldr_stall;
  logic          pc_wr_pending;
  logic          stall_d;
  logic          take_branch;

  // ALUOutM has priority over ResultW because it is the younger value.
  function automatic logic [1:0] fwd_sel(input logic match_m, input logic match_w,
                                         input logic wr_m, input logic wr_w);
    if (match_m && wr_m)      return 2'b10;
    else if (match_w && wr_w) return 2'b01;
    else                      return 2'b00;
  endfunction

  // Multi-cycle sequencer state register.
  // Reset aborts any sequence that is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Sequencer next state and stall request.
  // In BUSY, MultiCycleE is ignored: the op that started the sequence is
  // still the one held in E.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mc_stall   = 1'b0;
    case (state)
      IDLE: begin
        if (MultiCycleE && (MC_CYCLES > 1)) begin
          mc_stall   = 1'b1;
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          mc_stall = 1'b1;
          cnt_next = cnt - CW'(1);
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Hazard outputs.
  // Decode-side flushes are suppressed while D is stalled, so that a stalled
  // branch or redirect resolves again once D is released.
  // E is never cleared while it holds a multi-cycle op.
  always_comb begin
    ldr_stall     = Match_12D_E & MemtoRegE & RegWriteE;
    pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;
    stall_d       = ldr_stall | mc_stall;
    take_branch   = BranchTakenD & ~stall_d;

    ForwardAE   = 2'b00;
    ForwardBE   = 2'b00;
    ForwardCE   = 2'b00;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushM      = 1'b0;
    TakeBranchD = 1'b0;
    BusyE       = 1'b0;

    if (!reset) begin
      ForwardAE   = fwd_sel(Match_1E_M, Match_1E_W, RegWriteM, RegWriteW);
      ForwardBE   = fwd_sel(Match_2E_M, Match_2E_W, RegWriteM, RegWriteW);
      ForwardCE   = fwd_sel(Match_3E_M, Match_3E_W, RegWriteM, RegWriteW);
      StallE      = mc_stall;
      StallD      = stall_d;
      StallF      = stall_d | pc_wr_pending;
      FlushM      = mc_stall;
      FlushE      = (ldr_stall | take_branch) & ~mc_stall;
      TakeBranchD = take_branch;
      FlushD      = (pc_wr_pending | PCSrcW | take_branch) & ~stall_d;
      BusyE       = (state == BUSY) | mc_stall;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: checks two hazard_ctrl instances (MC_CYCLES=3 and
// MC_CYCLES=1) every cycle against a behavioural model. The model tracks how
// many cycles the current multi-cycle op has already spent in E.
// Directed steps with literal expectations are followed by random stimulus.
module tb_hazard_ctrl;

  typedef struct packed {
    logic rst;
    logic m1m, m1w, m2m, m2w, m3m, m3w, m12d;
    logic rwe, rwm, rww, meme;
    logic pcd, pce, pcm, pcw;
    logic bt, mce;
  } stim_t;

  typedef struct packed {
    logic [1:0] fa, fb, fc;
    logic sf, sd, se, fd, fe, fm, tk, busy;
  } exp_t;

  logic  clk = 1'b0;
  stim_t cur;
  int    errors = 0;
  int    checks = 0;
  int    res3 = 0;
  int    res1 = 0;

  always #5 clk = ~clk;

  logic [1:0] fa3, fb3, fc3, fa1, fb1, fc1;
  logic sf3, sd3, se3, fd3, fe3, fm3, tk3, busy3;
  logic sf1, sd1, se1, fd1, fe1, fm1, tk1, busy1;
  exp_t act3, act1;

  assign act3 = {fa3, fb3, fc3, sf3, sd3, se3, fd3, fe3, fm3, tk3, busy3};
  assign act1 = {fa1, fb1, fc1, sf1, sd1, se1, fd1, fe1, fm1, tk1, busy1};

  hazard_ctrl #(.MC_CYCLES(3), .CW(4)) dut (
    .clk(clk), .reset(cur.rst),
    .Match_1E_M(cur.m1m), .Match_1E_W(cur.m1w),
    .Match_2E_M(cur.m2m), .Match_2E_W(cur.m2w),
    .Match_3E_M(cur.m3m), .Match_3E_W(cur.m3w),
    .Match_12D_E(cur.m12d),
    .RegWriteE(cur.rwe), .RegWriteM(cur.rwm), .RegWriteW(cur.rww),
    .MemtoRegE(cur.meme),
    .PCSrcD(cur.pcd), .PCSrcE(cur.pce), .PCSrcM(cur.pcm), .PCSrcW(cur.pcw),
    .BranchTakenD(cur.bt), .MultiCycleE(cur.mce),
    .ForwardAE(fa3), .ForwardBE(fb3), .ForwardCE(fc3),
    .StallF(sf3), .StallD(sd3), .StallE(se3),
    .FlushD(fd3), .FlushE(fe3), .FlushM(fm3),
    .TakeBranchD(tk3), .BusyE(busy3)
  );

  hazard_ctrl #(.MC_CYCLES(1), .CW(4)) dut1 (
    .clk(clk), .reset(cur.rst),
    .Match_1E_M(cur.m1m), .Match_1E_W(cur.m1w),
    .Match_2E_M(cur.m2m), .Match_2E_W(cur.m2w),
    .Match_3E_M(cur.m3m), .Match_3E_W(cur.m3w),
    .Match_12D_E(cur.m12d),
    .RegWriteE(cur.rwe), .RegWriteM(cur.rwm), .RegWriteW(cur.rww),
    .MemtoRegE(cur.meme),
    .PCSrcD(cur.pcd), .PCSrcE(cur.pce), .PCSrcM(cur.pcm), .PCSrcW(cur.pcw),
    .BranchTakenD(cur.bt), .MultiCycleE(cur.mce),
    .ForwardAE(fa1), .ForwardBE(fb1), .ForwardCE(fc1),
    .StallF(sf1), .StallD(sd1), .StallE(se1),
    .FlushD(fd1), .FlushE(fe1), .FlushM(fm1),
    .TakeBranchD(tk1), .BusyE(busy1)
  );

  // res = cycles the current multi-cycle op has already spent in E.
  // The op is stalled until it has been in E for mc-1 cycles.
  function automatic exp_t model(input stim_t s, input int res, input int mc);
    exp_t e;
    logic in_op, mcs, ldr, pcw, sd, tk;
    e = '0;
    if (s.rst) return e;
    e.fa  = (s.m1m && s.rwm) ? 2'd2 : ((s.m1w && s.rww) ? 2'd1 : 2'd0);
    e.fb  = (s.m2m && s.rwm) ? 2'd2 : ((s.m2w && s.rww) ? 2'd1 : 2'd0);
    e.fc  = (s.m3m && s.rwm) ? 2'd2 : ((s.m3w && s.rww) ? 2'd1 : 2'd0);
    in_op = (res > 0) || s.mce;
    mcs   = in_op && (res < mc - 1);
    ldr   = s.m12d && s.meme && s.rwe;
    pcw   = s.pcd || s.pce || s.pcm;
    sd    = ldr || mcs;
    tk    = s.bt && !sd;
    e.se   = mcs;
    e.sd   = sd;
    e.sf   = sd || pcw;
    e.fm   = mcs;
    e.fe   = (ldr || tk) && !mcs;
    e.tk   = tk;
    e.fd   = (pcw || s.pcw || tk) && !sd;
    e.busy = in_op && (mc > 1);
    return e;
  endfunction

  function automatic int next_res(input stim_t s, input int res, input int mc);
    if (s.rst) return 0;
    if (((res > 0) || s.mce) && (res < mc - 1)) return res + 1;
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareAll(input string tag, input exp_t a, input exp_t e);
    checkOutput({tag, ".ForwardAE"},   a.fa,   e.fa);
    checkOutput({tag, ".ForwardBE"},   a.fb,   e.fb);
    checkOutput({tag, ".ForwardCE"},   a.fc,   e.fc);
    checkOutput({tag, ".StallF"},      a.sf,   e.sf);
    checkOutput({tag, ".StallD"},      a.sd,   e.sd);
    checkOutput({tag, ".StallE"},      a.se,   e.se);
    checkOutput({tag, ".FlushD"},      a.fd,   e.fd);
    checkOutput({tag, ".FlushE"},      a.fe,   e.fe);
    checkOutput({tag, ".FlushM"},      a.fm,   e.fm);
    checkOutput({tag, ".TakeBranchD"}, a.tk,   e.tk);
    checkOutput({tag, ".BusyE"},       a.busy, e.busy);
  endtask

  // Inputs change #1 after the rising edge and hold until the next one, so
  // advancing the model on the falling edge equals advancing it on the edge.
  always @(negedge clk) begin
    compareAll("mc3", act3, model(cur, res3, 3));
    compareAll("mc1", act1, model(cur, res1, 1));
    res3 <= next_res(cur, res3, 3);
    res1 <= next_res(cur, res1, 1);
  end

  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    cur = s;
    @(negedge clk);
  endtask

  initial begin
    stim_t s;
    logic [17:0] bits;
    cur     = '0;
    cur.rst = 1'b1;

    // Reset forces every output low, whatever the inputs are.
    s = '0; s.rst = 1; s.mce = 1; s.m1m = 1; s.rwm = 1; s.m12d = 1; s.meme = 1;
    s.rwe = 1; s.bt = 1; s.pcd = 1;
    applyStimulus(s);
    checkOutput("lit.reset.StallF", sf3, 2'd0);
    checkOutput("lit.reset.ForwardAE", fa3, 2'd0);
    checkOutput("lit.reset.BusyE", busy3, 2'd0);
    checkOutput("lit.reset.FlushD", fd3, 2'd0);

    // Forwarding priority.
    s = '0; s.m1m = 1; s.rwm = 1;
    applyStimulus(s);
    checkOutput("lit.fwd.M", fa3, 2'b10);
    checkOutput("lit.fwd.M.nostall", sf3, 2'd0);
    s.m1w = 1; s.rww = 1;
    applyStimulus(s);
    checkOutput("lit.fwd.MW", fa3, 2'b10);
    s.m1m = 0; s.m2w = 1;
    applyStimulus(s);
    checkOutput("lit.fwd.W", fa3, 2'b01);
    checkOutput("lit.fwd.B.W", fb3, 2'b01);

    // Load-use: one stall cycle, then release.
    s = '0; s.m12d = 1; s.meme = 1; s.rwe = 1;
    applyStimulus(s);
    checkOutput("lit.ldr.StallF", sf3, 2'd1);
    checkOutput("lit.ldr.StallD", sd3, 2'd1);
    checkOutput("lit.ldr.FlushE", fe3, 2'd1);
    s = '0;
    applyStimulus(s);
    checkOutput("lit.ldr.release", sf3, 2'd0);

    // Multi-cycle op, with a taken branch during the first stall cycle.
    s = '0; s.mce = 1; s.bt = 1;
    applyStimulus(s);
    checkOutput("lit.mc0.StallE", se3, 2'd1);
    checkOutput("lit.mc0.FlushM", fm3, 2'd1);
    checkOutput("lit.mc0.TakeBranchD", tk3, 2'd0);
    checkOutput("lit.mc0.FlushE", fe3, 2'd0);
    checkOutput("lit.mc0.FlushD", fd3, 2'd0);
    checkOutput("lit.mc1x.StallE", se1, 2'd0);
    checkOutput("lit.mc1x.TakeBranchD", tk1, 2'd1);
    s.bt = 0;
    applyStimulus(s);
    checkOutput("lit.mc1.StallF", sf3, 2'd1);
    applyStimulus(s);
    checkOutput("lit.mc2.StallE", se3, 2'd0);
    checkOutput("lit.mc2.BusyE", busy3, 2'd1);
    s.mce = 0;
    applyStimulus(s);
    checkOutput("lit.mc3.BusyE", busy3, 2'd0);

    // Branch with no stall.
    s = '0; s.bt = 1;
    applyStimulus(s);
    checkOutput("lit.br.TakeBranchD", tk3, 2'd1);
    checkOutput("lit.br.FlushE", fe3, 2'd1);
    checkOutput("lit.br.FlushD", fd3, 2'd1);

    // R15 write travelling D, E, M, W.
    s = '0; s.pcd = 1;
    applyStimulus(s);
    checkOutput("lit.pcD.StallF", sf3, 2'd1);
    s = '0; s.pce = 1;
    applyStimulus(s);
    s = '0; s.pcm = 1;
    applyStimulus(s);
    checkOutput("lit.pcM.StallF", sf3, 2'd1);
    s = '0; s.pcw = 1;
    applyStimulus(s);
    checkOutput("lit.pcW.StallF", sf3, 2'd0);
    checkOutput("lit.pcW.FlushD", fd3, 2'd1);
    s = '0;
    applyStimulus(s);
    checkOutput("lit.pc.done.FlushD", fd3, 2'd0);

    // Reset during the second cycle of a multi-cycle op.
    s = '0; s.mce = 1;
    applyStimulus(s);
    s.rst = 1;
    applyStimulus(s);
    checkOutput("lit.rstbusy.StallF", sf3, 2'd0);
    checkOutput("lit.rstbusy.BusyE", busy3, 2'd0);
    s = '0;
    applyStimulus(s);
    checkOutput("lit.postrst.StallF", sf3, 2'd0);
    checkOutput("lit.postrst.BusyE", busy3, 2'd0);
    applyStimulus(s);
    checkOutput("lit.postrst2.StallE", se3, 2'd0);

    // Random traffic; reset is rare and multi-cycle ops are moderately common.
    for (int i = 0; i < 3000; i++) begin
      bits  = 18'($urandom);
      s     = bits;
      s.rst = ($urandom_range(0, 39) == 0);
      s.mce = ($urandom_range(0, 3) == 0);
      applyStimulus(s);
    end

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
